// File: rtl/ball_direction_ctrl_pkg.sv
// Shared definitions for the pong ball direction controller: FSM encoding,
// compass-style heading constants, default field geometry and small helpers.
package ball_direction_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_EVAL  = 2'd2,
      ST_GOAL  = 2'd3
   } state_t;

   localparam logic [3:0] DIR_UP    = 4'd0;
   localparam logic [3:0] DIR_RIGHT = 4'd4;
   localparam logic [3:0] DIR_DOWN  = 4'd8;
   localparam logic [3:0] DIR_LEFT  = 4'd12;

   // Heading the ball is served with after the left/right player scored.
   localparam logic [3:0] SERVE_DIR_L = 4'd5;
   localparam logic [3:0] SERVE_DIR_R = 4'd11;

   localparam int FIELD_W_DEF    = 2560;
   localparam int FIELD_H_DEF    = 1920;
   localparam int PADDLE_L_X_DEF = 80;
   localparam int PADDLE_R_X_DEF = 2480;

   function automatic logic is_up(input logic [3:0] d);
      return (d < DIR_RIGHT) || (d > DIR_LEFT);
   endfunction

   function automatic logic is_down(input logic [3:0] d);
      return (d > DIR_RIGHT) && (d < DIR_LEFT);
   endfunction

   function automatic logic is_left(input logic [3:0] d);
      return d > DIR_DOWN;
   endfunction

   function automatic logic is_right(input logic [3:0] d);
      return (d > DIR_UP) && (d < DIR_DOWN);
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
      return (s < lim) ? s + 4'd1 : s;
   endfunction

endpackage

// File: rtl/ball_direction_ctrl_dir_reflect.sv
// Combinational wall/paddle reflection and goal detection for one heading.
// Geometry is compared in 14 bits so x-size and x+size never wrap.
module dir_reflect
   import ball_direction_ctrl_pkg::*;
#(
   parameter int FIELD_W    = FIELD_W_DEF,
   parameter int FIELD_H    = FIELD_H_DEF,
   parameter int PADDLE_L_X = PADDLE_L_X_DEF,
   parameter int PADDLE_R_X = PADDLE_R_X_DEF
) (
   input  logic [3:0]  d,
   input  logic [12:0] x,
   input  logic [12:0] y,
   input  logic [12:0] size,
   input  logic [12:0] paddle_l_y,
   input  logic [12:0] paddle_r_y,
   input  logic [12:0] paddle_half,
   output logic [3:0]  new_dir,
   output logic        goal_l,
   output logic        goal_r
);
   localparam logic signed [13:0] FW_S = 14'(FIELD_W);
   localparam logic signed [13:0] FH_S = 14'(FIELD_H);
   localparam logic signed [13:0] PL_S = 14'(PADDLE_L_X);
   localparam logic        [13:0] PR_U = 14'(PADDLE_R_X);

   logic signed [13:0] xs, ys, ss, ply, pry, off_l, off_r;
   logic        [13:0] right_edge, reach, thr, mag_l, mag_r;
   logic               up, down, left, right, wall, hit_l, hit_r;
   logic               above, below;
   logic        [3:0]  v, r;

   assign xs  = {1'b0, x};
   assign ys  = {1'b0, y};
   assign ss  = {1'b0, size};
   assign ply = {1'b0, paddle_l_y};
   assign pry = {1'b0, paddle_r_y};

   assign up    = is_up(d);
   assign down  = is_down(d);
   assign left  = is_left(d);
   assign right = is_right(d);

   assign right_edge = {1'b0, x} + {1'b0, size};
   assign reach      = {1'b0, paddle_half} + {1'b0, size};
   assign thr        = {1'b0, paddle_half} >> 1;
   assign off_l      = ys - ply;
   assign off_r      = ys - pry;
   assign mag_l      = off_l[13] ? 14'(-off_l) : 14'(off_l);
   assign mag_r      = off_r[13] ? 14'(-off_r) : 14'(off_r);

   assign wall  = (up && (y <= size)) || (down && (ys >= FH_S - ss));
   assign hit_l = left && ((xs - ss) <= PL_S) && (mag_l <= reach);
   assign hit_r = right && (right_edge >= PR_U) && (mag_r <= reach);

   assign goal_r = left && (x <= size) && !hit_l;
   assign goal_l = right && (xs >= FW_S - ss) && !hit_r;

   // Vertical reflection first, then paddle mirror with off-centre steepening.
   always_comb begin
      v       = d;
      r       = 4'd0;
      above   = 1'b0;
      below   = 1'b0;
      new_dir = d;
      if (wall) begin
         v = 4'd8 - d;
      end else begin
         v = d;
      end
      r = 4'd0 - v;
      if (hit_l) begin
         above = off_l[13] && (mag_l > thr);
         below = !off_l[13] && (mag_l > thr);
      end else begin
         above = off_r[13] && (mag_r > thr);
         below = !off_r[13] && (mag_r > thr);
      end
      if (hit_l) begin
         if (above) begin
            new_dir = (r > 4'd2) ? r - 4'd1 : r;
         end else if (below) begin
            new_dir = (r < 4'd6) ? r + 4'd1 : r;
         end else begin
            new_dir = r;
         end
      end else if (hit_r) begin
         if (above) begin
            new_dir = (r < 4'd14) ? r + 4'd1 : r;
         end else if (below) begin
            new_dir = (r > 4'd10) ? r - 4'd1 : r;
         end else begin
            new_dir = r;
         end
      end else begin
         new_dir = v;
      end
   end

endmodule

// File: rtl/ball_direction_ctrl.sv
// Pong ball sequencer: serve delay, per-frame move strobe, two-cycle
// collision evaluation, goal strobes and saturating scores.
module ball_direction_ctrl
   import ball_direction_ctrl_pkg::*;
#(
   parameter int FIELD_W      = FIELD_W_DEF,
   parameter int FIELD_H      = FIELD_H_DEF,
   parameter int PADDLE_L_X   = PADDLE_L_X_DEF,
   parameter int PADDLE_R_X   = PADDLE_R_X_DEF,
   parameter int SERVE_FRAMES = 60,
   parameter int MAX_SCORE    = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [12:0] x_in,
   input  logic [12:0] y_in,
   input  logic [12:0] size,
   input  logic [12:0] paddle_l_y,
   input  logic [12:0] paddle_r_y,
   input  logic [12:0] paddle_half,
   output logic [3:0]  direction,
   output logic        move,
   output logic        ball_rst,
   output logic        goal_l,
   output logic        goal_r,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r
);
   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   state_t           state, state_nxt;
   logic             eval2, eval2_nxt, boot;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       dir_nxt, score_l_nxt, score_r_nxt, new_dir;
   logic             goal_l_nxt, goal_r_nxt, ball_rst_nxt, hit_gl, hit_gr;

   dir_reflect #(
      .FIELD_W    (FIELD_W),
      .FIELD_H    (FIELD_H),
      .PADDLE_L_X (PADDLE_L_X),
      .PADDLE_R_X (PADDLE_R_X)
   ) u_reflect (
      .d           (direction),
      .x           (x_in),
      .y           (y_in),
      .size        (size),
      .paddle_l_y  (paddle_l_y),
      .paddle_r_y  (paddle_r_y),
      .paddle_half (paddle_half),
      .new_dir     (new_dir),
      .goal_l      (hit_gl),
      .goal_r      (hit_gr)
   );

   // Next-state, move strobe and registered-output next values.
   always_comb begin
      state_nxt    = state;
      eval2_nxt    = 1'b0;
      cnt_nxt      = cnt;
      dir_nxt      = direction;
      score_l_nxt  = score_l;
      score_r_nxt  = score_r;
      goal_l_nxt   = 1'b0;
      goal_r_nxt   = 1'b0;
      ball_rst_nxt = boot;
      move         = 1'b0;
      case (state)
         ST_SERVE: begin
            if (frame_tick) begin
               if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_PLAY;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               cnt_nxt = cnt;
            end
         end
         ST_PLAY: begin
            if (frame_tick) begin
               move      = 1'b1;
               state_nxt = ST_EVAL;
            end else begin
               state_nxt = ST_PLAY;
            end
         end
         ST_EVAL: begin
            // First cycle only waits for the position block to apply the step.
            if (!eval2) begin
               eval2_nxt = 1'b1;
            end else if (hit_gr) begin
               state_nxt   = ST_GOAL;
               goal_r_nxt  = 1'b1;
               score_r_nxt = sat_inc(score_r, 4'(MAX_SCORE));
               dir_nxt     = SERVE_DIR_R;
            end else if (hit_gl) begin
               state_nxt   = ST_GOAL;
               goal_l_nxt  = 1'b1;
               score_l_nxt = sat_inc(score_l, 4'(MAX_SCORE));
               dir_nxt     = SERVE_DIR_L;
            end else begin
               state_nxt = ST_PLAY;
               dir_nxt   = new_dir;
            end
         end
         ST_GOAL: begin
            state_nxt    = ST_SERVE;
            cnt_nxt      = '0;
            ball_rst_nxt = 1'b1;
         end
         default: begin
            state_nxt = ST_SERVE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and output registers; boot makes ball_rst fire right after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_SERVE;
         eval2     <= 1'b0;
         cnt       <= '0;
         direction <= SERVE_DIR_L;
         score_l   <= 4'd0;
         score_r   <= 4'd0;
         goal_l    <= 1'b0;
         goal_r    <= 1'b0;
         ball_rst  <= 1'b0;
         boot      <= 1'b1;
      end else begin
         state     <= state_nxt;
         eval2     <= eval2_nxt;
         cnt       <= cnt_nxt;
         direction <= dir_nxt;
         score_l   <= score_l_nxt;
         score_r   <= score_r_nxt;
         goal_l    <= goal_l_nxt;
         goal_r    <= goal_r_nxt;
         ball_rst  <= ball_rst_nxt;
         boot      <= 1'b0;
      end
   end

endmodule
